// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : imem_pkg                                                         |
// | Brief   : Shared types and default geometry for the imem port arbiter.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package imem_pkg;

  localparam int IMEM_DEPTH      = 1024;
  localparam int IMEM_ADDR_WIDTH = 10;

  typedef logic [IMEM_ADDR_WIDTH-1:0] waddr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } ldst_t;

endpackage
`default_nettype wire

// File: rtl/imem_load_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imem_load_arbiter                                                 |
// | Brief  : Shares the imem address/write port between instruction fetch and  |
// |          a block program loader; the loader owns the port while loading.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module imem_load_arbiter #(
  parameter int IMEM_DEPTH      = imem_pkg::IMEM_DEPTH,
  parameter int IMEM_ADDR_WIDTH = imem_pkg::IMEM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  // program loader
  input  logic                       ld_start,
  input  logic [IMEM_ADDR_WIDTH-1:0] ld_base,
  input  logic [IMEM_ADDR_WIDTH:0]   ld_count,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_data,
  output logic                       ld_ready,
  output logic                       ld_busy,
  output logic                       ld_done,
  // fetch path
  input  logic                       f_req,
  input  logic [31:0]                f_pc,
  output logic                       f_stall,
  output logic                       f_valid,
  output logic [31:0]                f_instr,
  output logic                       f_misalign,
  // instruction memory
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_wren,
  output logic [31:0]                imem_din,
  input  logic [31:0]                imem_dout
);

  import imem_pkg::ldst_t;
  import imem_pkg::S_IDLE;
  import imem_pkg::S_LOAD;

  localparam int c_aw = IMEM_ADDR_WIDTH;

  ldst_t           r_state;
  ldst_t           w_state_nxt;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] w_wr_ptr_nxt;
  logic [c_aw-1:0] w_wr_ptr_inc;
  logic [c_aw:0]   r_remaining;
  logic [c_aw:0]   w_remaining_nxt;
  logic            r_ld_done;
  logic            w_ld_done_nxt;

  logic            w_f_grant;
  logic            w_f_stall;
  logic            w_ld_ready;
  logic            w_ld_busy;
  logic            w_imem_wren;
  logic [c_aw-1:0] w_imem_addr;

  logic            r_f_valid;
  logic [31:0]     r_f_instr;
  logic            r_f_misalign;

  // PC bits above the word address never reach imem
  logic            w_unused_pc;
  assign w_unused_pc = ^f_pc[31:c_aw+2];

  // Wrap explicitly so a non-power-of-two depth still stays in range
  assign w_wr_ptr_inc = (r_wr_ptr == c_aw'(IMEM_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_remaining_nxt = r_remaining;
    w_ld_done_nxt   = 1'b0;
    w_imem_addr     = f_pc[c_aw+1:2];
    w_imem_wren     = 1'b0;
    w_ld_ready      = 1'b0;
    w_ld_busy       = 1'b0;
    w_f_stall       = 1'b0;
    w_f_grant       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_f_grant = f_req;
        if (ld_start) begin
          if (ld_count != '0) begin
            w_state_nxt     = S_LOAD;
            w_wr_ptr_nxt    = ld_base;
            w_remaining_nxt = ld_count;
          end else begin
            w_ld_done_nxt = 1'b1;
          end
        end
      end

      S_LOAD: begin
        w_ld_busy   = 1'b1;
        w_ld_ready  = 1'b1;
        w_f_stall   = f_req;
        w_imem_addr = r_wr_ptr;
        w_imem_wren = ld_valid;
        if (ld_valid) begin
          w_wr_ptr_nxt    = w_wr_ptr_inc;
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == (c_aw+1)'(1)) begin
            w_state_nxt   = S_IDLE;
            w_ld_done_nxt = 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_ld_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_ld_done   <= w_ld_done_nxt;
    end
  end

  // Fetch result registers: f_instr holds across refused cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_valid    <= 1'b0;
      r_f_instr    <= '0;
      r_f_misalign <= 1'b0;
    end else begin
      r_f_valid <= w_f_grant;
      if (w_f_grant) begin
        r_f_instr    <= imem_dout;
        r_f_misalign <= |f_pc[1:0];
      end
    end
  end

  assign ld_ready   = w_ld_ready;
  assign ld_busy    = w_ld_busy;
  assign ld_done    = r_ld_done;
  assign f_stall    = w_f_stall;
  assign f_valid    = r_f_valid;
  assign f_instr    = r_f_instr;
  assign f_misalign = r_f_misalign;
  assign imem_addr  = w_imem_addr;
  assign imem_wren  = w_imem_wren;
  assign imem_din   = ld_data;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_imem_load_arbiter                                              |
// | Brief  : Self-checking bench for imem_load_arbiter with a word-level model. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_imem_load_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_count;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          f_req;
  logic [31:0]   f_pc;
  logic          f_stall;
  logic          f_valid;
  logic [31:0]   f_instr;
  logic          f_misalign;
  logic [AW-1:0] imem_addr;
  logic          imem_wren;
  logic [31:0]   imem_din;
  logic [31:0]   imem_dout;

  // memory attached to the DUT plus a preload port for the bench
  logic [31:0]   mem [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  // reference contents: what imem must hold according to the load rules
  logic [31:0]   exp_mem [DEPTH];
  logic [31:0]   last_instr;

  int checks = 0;
  int errors = 0;

  imem_load_arbiter #(.IMEM_DEPTH(DEPTH), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .f_req      (f_req),
    .f_pc       (f_pc),
    .f_stall    (f_stall),
    .f_valid    (f_valid),
    .f_instr    (f_instr),
    .f_misalign (f_misalign),
    .imem_addr  (imem_addr),
    .imem_wren  (imem_wren),
    .imem_din   (imem_din),
    .imem_dout  (imem_dout)
  );

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr];

  always @(posedge clk) begin
    if (imem_wren) mem[imem_addr] <= imem_din;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] widx(input logic [31:0] pc);
    return pc[AW+1:2];
  endfunction

  task automatic fetch(input logic [31:0] pc);
    f_req = 1'b1;
    f_pc  = pc;
    @(negedge clk);
    chk("fetch_stall", {31'd0, f_stall}, 32'd0);
    chk("fetch_addr", {22'd0, imem_addr}, {22'd0, widx(pc)});
    tick();
    f_req = 1'b0;
    last_instr = exp_mem[widx(pc)];
    chk("fetch_valid", {31'd0, f_valid}, 32'd1);
    chk("fetch_instr", f_instr, last_instr);
    chk("fetch_misalign", {31'd0, f_misalign}, {31'd0, |pc[1:0]});
  endtask

  // One complete block load; optionally holds a fetch request throughout
  task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] count,
                          input bit bubbles, input bit hold_fetch, input bit fixed_data,
                          input logic [31:0] pc);
    int accepted = 0;
    int guard    = 0;
    bit v;
    logic [31:0] d;
    ld_start = 1'b1;
    ld_base  = base;
    ld_count = count;
    f_req    = hold_fetch;
    f_pc     = pc;
    @(negedge clk);
    chk("start_busy", {31'd0, ld_busy}, 32'd0);
    chk("start_stall", {31'd0, f_stall}, 32'd0);
    tick();
    ld_start = 1'b0;
    if (hold_fetch) begin
      last_instr = exp_mem[widx(pc)];
      chk("start_fvalid", {31'd0, f_valid}, 32'd1);
      chk("start_finstr", f_instr, last_instr);
    end
    if (count == '0) begin
      f_req = 1'b0;
      chk("zero_done", {31'd0, ld_done}, 32'd1);
      chk("zero_busy", {31'd0, ld_busy}, 32'd0);
      @(negedge clk);
      chk("zero_wren", {31'd0, imem_wren}, 32'd0);
      tick();
      chk("zero_done_once", {31'd0, ld_done}, 32'd0);
      return;
    end
    while (accepted < int'(count) && guard < 20000) begin
      guard++;
      v = bubbles ? (guard != 2 && $urandom_range(0, 3) != 0) : 1'b1;
      d = fixed_data ? 32'hA + 32'(accepted) : $urandom;
      ld_valid = v;
      ld_data  = d;
      ld_start = ($urandom_range(0, 4) == 0);
      ld_base  = AW'($urandom);
      ld_count = (AW+1)'($urandom);
      @(negedge clk);
      chk("load_busy", {31'd0, ld_busy}, 32'd1);
      chk("load_ready", {31'd0, ld_ready}, 32'd1);
      chk("load_done_low", {31'd0, ld_done}, 32'd0);
      chk("load_wren", {31'd0, imem_wren}, {31'd0, v});
      chk("load_stall", {31'd0, f_stall}, {31'd0, hold_fetch});
      if (v) begin
        chk("load_addr", {22'd0, imem_addr}, 32'((int'(base) + accepted) % DEPTH));
        chk("load_din", imem_din, d);
        exp_mem[(int'(base) + accepted) % DEPTH] = d;
        accepted++;
      end
      tick();
      ld_start = 1'b0;
      if (hold_fetch) begin
        chk("load_fvalid", {31'd0, f_valid}, 32'd0);
        chk("load_fhold", f_instr, last_instr);
      end
    end
    ld_valid = 1'b0;
    if (guard >= 20000) chk("load_timeout", 32'd1, 32'd0);
    chk("end_done", {31'd0, ld_done}, 32'd1);
    chk("end_busy", {31'd0, ld_busy}, 32'd0);
    @(negedge clk);
    chk("end_stall", {31'd0, f_stall}, 32'd0);
    tick();
    f_req = 1'b0;
    chk("end_done_once", {31'd0, ld_done}, 32'd0);
    if (hold_fetch) begin
      last_instr = exp_mem[widx(pc)];
      chk("end_fvalid", {31'd0, f_valid}, 32'd1);
      chk("end_finstr", f_instr, last_instr);
    end
  endtask

  initial begin
    int diffs;
    logic [31:0] w;
    bit g;
    logic [31:0] pc;

    reset = 1'b1; ld_start = 1'b0; ld_base = '0; ld_count = '0;
    ld_valid = 1'b0; ld_data = '0; f_req = 1'b0; f_pc = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; last_instr = '0;

    // preload imem while the DUT is held in reset
    for (int i = 0; i < DEPTH; i++) begin
      w = (i == 2) ? 32'h0050_0093 : $urandom;
      exp_mem[i] = w;
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = w;
      tick();
    end
    bd_we = 1'b0;

    chk("rst_fvalid", {31'd0, f_valid}, 32'd0);
    chk("rst_finstr", f_instr, 32'd0);
    chk("rst_misalign", {31'd0, f_misalign}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_wren", {31'd0, imem_wren}, 32'd0);
    reset = 1'b0;
    tick();

    // test 1: plain fetch of word 2
    fetch(32'h8);
    chk("t1_instr_const", f_instr, 32'h0050_0093);

    // tests 2/3: three-word load with a bubble and a fetch held throughout
    run_load(10'd4, 11'd3, 1'b1, 1'b1, 1'b1, 32'h14);
    chk("t2_mem4", mem[4], 32'hA);
    chk("t2_mem5", mem[5], 32'hB);
    chk("t2_mem6", mem[6], 32'hC);
    chk("t3_new_word", f_instr, 32'hB);

    // test 4: block wrapping past the top of imem
    run_load(10'd1022, 11'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_mem1022", mem[1022], exp_mem[1022]);
    chk("t4_mem0", mem[0], exp_mem[0]);
    chk("t4_mem1", mem[1], exp_mem[1]);
    chk("t4_mem2_kept", mem[2], 32'h0050_0093);

    // test 5: empty block
    run_load(10'd300, 11'd0, 1'b0, 1'b0, 1'b0, 32'h0);

    // test 6: reset after two of five words
    ld_start = 1'b1; ld_base = 10'd100; ld_count = 11'd5;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      ld_valid = 1'b1; ld_data = w;
      exp_mem[100 + i] = w;
      tick();
    end
    ld_data = $urandom;
    reset = 1'b1;
    #1;
    chk("t6_busy_abort", {31'd0, ld_busy}, 32'd0);
    chk("t6_wren_abort", {31'd0, imem_wren}, 32'd0);
    chk("t6_rst_finstr", f_instr, 32'd0);
    ld_valid = 1'b0;
    tick();
    reset = 1'b0;
    last_instr = '0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_done", {31'd0, ld_done}, 32'd0);
      tick();
    end
    chk("t6_mem100", mem[100], exp_mem[100]);
    chk("t6_mem101", mem[101], exp_mem[101]);
    chk("t6_mem102_kept", mem[102], exp_mem[102]);
    run_load(10'd100, 11'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch(32'h6);
    chk("t6_misalign", {31'd0, f_misalign}, 32'd1);

    // full-depth load starting at a random base
    run_load(AW'($urandom), 11'd1024, 1'b1, 1'b0, 1'b0, 32'h0);

    // random fetch traffic against the model
    for (int i = 0; i < 200; i++) begin
      g  = 1'($urandom_range(0, 1));
      pc = $urandom;
      f_req = g; f_pc = pc;
      @(negedge clk);
      chk("rnd_stall", {31'd0, f_stall}, 32'd0);
      chk("rnd_addr", {22'd0, imem_addr}, {22'd0, widx(pc)});
      tick();
      chk("rnd_fvalid", {31'd0, f_valid}, {31'd0, g});
      if (g) begin
        last_instr = exp_mem[widx(pc)];
        chk("rnd_misalign", {31'd0, f_misalign}, {31'd0, |pc[1:0]});
      end
      chk("rnd_finstr", f_instr, last_instr);
    end
    f_req = 1'b0;

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) diffs++;
    chk("mem_scan", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
